// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: FSM states, instruction size and reset vector.
// FETCH_MISALIGN_TRAP_EN adds the TRAP state used by misaligned-redirect trapping.
package cpu_pkg;

  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
`ifdef FETCH_MISALIGN_TRAP_EN
    STALL = 2'd2,
    TRAP  = 2'd3
`else
    STALL = 2'd2
`endif
  } fetchState_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and memory (slave).
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/twoToOneMux_32.sv
// 32-bit two-input multiplexer; sel=1 picks b.
module twoToOneMux_32 (
  input  logic        sel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential/redirected PC, imem handshake, registered IF outputs.
// Define FETCH_MISALIGN_TRAP_EN to add the misalign_trap output and TRAP state.
module fetch_unit import cpu_pkg::*; #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   next_pc,
  input  logic          redirect,
  input  logic          stall,
  fetch_unit_if.master  imem,
  output logic [31:0]   if_instr,
  output logic [31:0]   if_pc,
  output logic          if_valid
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic          misalign_trap
`endif
);

  fetchState_t state;
  logic [31:0] fetchPc;
  logic [31:0] seqPc;
  logic [31:0] redirectPc;
  logic [31:0] pcNext;

  assign seqPc = fetchPc + INSTR_BYTES;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |next_pc[1:0];
  assign redirectPc = next_pc;
`else
  assign redirectPc = next_pc & ~32'h3;
`endif

  twoToOneMux_32 pcMux (
    .sel (redirect),
    .a   (seqPc),
    .b   (redirectPc),
    .y   (pcNext)
  );

  assign imem.imem_addr = fetchPc;
  // A held valid word under stall blocks the request so no ack can overwrite it.
  assign imem.imem_req  = !rst && (state == REQ) && !(if_valid && stall);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetchPc  <= RESET_PC;
      if_instr <= '0;
      if_pc    <= RESET_PC;
      if_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_trap <= 1'b0;
`endif
    end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_trap <= 1'b0;
`endif
      case (state)
        IDLE: state <= REQ;
        REQ, STALL: begin
`ifdef FETCH_MISALIGN_TRAP_EN
          if (redirect && misaligned) begin
            misalign_trap <= 1'b1;
            if_valid      <= 1'b0;
            state         <= TRAP;
          end else
`endif
          if (redirect) begin
            fetchPc  <= pcNext;
            if_valid <= 1'b0;
            state    <= REQ;
          end else if (state == STALL) begin
            if (!stall) state <= REQ;
          end else if (if_valid && stall) begin
            state <= STALL;
          end else if (imem.imem_ack) begin
            if_instr <= imem.imem_rdata;
            if_pc    <= fetchPc;
            if_valid <= 1'b1;
            fetchPc  <= pcNext;
          end else if (!stall) begin
            if_valid <= 1'b0;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        TRAP: state <= TRAP;
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scenario bench for fetch_unit; accepted fetches are queued and checked when they reach the IF outputs.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic        redirect;
  logic        stall;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  always #5 clk = ~clk;

  fetch_unit_if imemBus ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk      (clk),
    .rst      (rst),
    .next_pc  (next_pc),
    .redirect (redirect),
    .stall    (stall),
    .imem     (imemBus),
    .if_instr (if_instr),
    .if_pc    (if_pc),
    .if_valid (if_valid)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_trap (misalign_trap)
`endif
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetchRec_t;

  fetchRec_t sb[$];
  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[31:16]};
  endfunction

  always_comb imemBus.imem_rdata = memWord(imemBus.imem_addr);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; redirect = 1'b0; stall = 1'b0; next_pc = '0;
    imemBus.imem_ack = 1'b1;
    tick(); tick(); #1;
    total++; if (imemBus.imem_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", imemBus.imem_req); end
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", if_valid); end
    total++; if (if_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got %h want 00000000", if_pc); end
    total++; if (if_instr !== 32'h0) begin bad++; $display("FAIL reset_instr: got %h want 00000000", if_instr); end
    total++; if (imemBus.imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 00000000", imemBus.imem_addr); end
  endtask

  task automatic test_sequential;
    fetchRec_t expRec;
    logic [31:0] expPc;
    rst = 1'b0; #1;
    total++; if (imemBus.imem_req !== 1'b0) begin bad++; $display("FAIL idle_req: got %b want 0", imemBus.imem_req); end
    tick();
    expPc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({imemBus.imem_req, imemBus.imem_addr} !== {1'b1, expPc}) begin
        bad++; $display("FAIL seq_addr: got req=%b addr=%h want req=1 addr=%h", imemBus.imem_req, imemBus.imem_addr, expPc);
      end
      sb.push_back('{pc: expPc, instr: memWord(expPc)});
      tick();
      total++;
      expRec = sb.pop_front();
      if ({if_valid, if_pc, if_instr} !== {1'b1, expRec.pc, expRec.instr}) begin
        bad++; $display("FAIL seq_out: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", if_valid, if_pc, if_instr, expRec.pc, expRec.instr);
      end
      expPc += 32'd4;
    end
  endtask

  task automatic test_stall;
    fetchRec_t expRec;
    stall = 1'b1; #1;
    total++; if (imemBus.imem_req !== 1'b0) begin bad++; $display("FAIL stall_req0: got %b want 0", imemBus.imem_req); end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if ({imemBus.imem_req, if_valid, if_pc, if_instr} !== {1'b0, 1'b1, 32'h8, memWord(32'h8)}) begin
        bad++; $display("FAIL stall_hold: got req=%b v=%b pc=%h instr=%h want req=0 v=1 pc=00000008 instr=%h",
                        imemBus.imem_req, if_valid, if_pc, if_instr, memWord(32'h8));
      end
    end
    stall = 1'b0; #1;
    total++; if (imemBus.imem_req !== 1'b0) begin bad++; $display("FAIL stall_release_req: got %b want 0", imemBus.imem_req); end
    tick();
    total++;
    if ({imemBus.imem_req, imemBus.imem_addr} !== {1'b1, 32'hC}) begin
      bad++; $display("FAIL stall_resume_addr: got req=%b addr=%h want req=1 addr=0000000c", imemBus.imem_req, imemBus.imem_addr);
    end
    sb.push_back('{pc: 32'hC, instr: memWord(32'hC)});
    tick();
    total++;
    expRec = sb.pop_front();
    if ({if_valid, if_pc, if_instr} !== {1'b1, expRec.pc, expRec.instr}) begin
      bad++; $display("FAIL stall_resume_out: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", if_valid, if_pc, if_instr, expRec.pc, expRec.instr);
    end
  endtask

  task automatic test_redirect;
    fetchRec_t expRec;
    redirect = 1'b1; next_pc = 32'h100; imemBus.imem_ack = 1'b1;
    tick();
    redirect = 1'b0; #1;
    total++;
    if ({if_valid, imemBus.imem_req, imemBus.imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
      bad++; $display("FAIL redir_discard: got v=%b req=%b addr=%h want v=0 req=1 addr=00000100", if_valid, imemBus.imem_req, imemBus.imem_addr);
    end
    sb.push_back('{pc: 32'h100, instr: memWord(32'h100)});
    tick();
    total++;
    expRec = sb.pop_front();
    if ({if_valid, if_pc, if_instr} !== {1'b1, expRec.pc, expRec.instr}) begin
      bad++; $display("FAIL redir_out: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", if_valid, if_pc, if_instr, expRec.pc, expRec.instr);
    end
  endtask

  task automatic test_ack_delay;
    fetchRec_t expRec;
    imemBus.imem_ack = 1'b0; redirect = 1'b1; next_pc = 32'h20;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({if_valid, imemBus.imem_req, imemBus.imem_addr} !== {1'b0, 1'b1, 32'h20}) begin
        bad++; $display("FAIL delay_wait: got v=%b req=%b addr=%h want v=0 req=1 addr=00000020", if_valid, imemBus.imem_req, imemBus.imem_addr);
      end
      tick();
    end
    imemBus.imem_ack = 1'b1; #1;
    total++; if (imemBus.imem_addr !== 32'h20) begin bad++; $display("FAIL delay_addr: got %h want 00000020", imemBus.imem_addr); end
    sb.push_back('{pc: 32'h20, instr: memWord(32'h20)});
    tick();
    total++;
    expRec = sb.pop_front();
    if ({if_valid, if_pc, if_instr} !== {1'b1, expRec.pc, expRec.instr}) begin
      bad++; $display("FAIL delay_out: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", if_valid, if_pc, if_instr, expRec.pc, expRec.instr);
    end
  endtask

  task automatic test_wrap;
    fetchRec_t expRec;
    logic [31:0] expPc;
    imemBus.imem_ack = 1'b0; redirect = 1'b1; next_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0; imemBus.imem_ack = 1'b1;
    expPc = 32'hFFFF_FFF8;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (imemBus.imem_addr !== expPc) begin bad++; $display("FAIL wrap_addr: got %h want %h", imemBus.imem_addr, expPc); end
      sb.push_back('{pc: expPc, instr: memWord(expPc)});
      tick();
      total++;
      expRec = sb.pop_front();
      if ({if_valid, if_pc, if_instr} !== {1'b1, expRec.pc, expRec.instr}) begin
        bad++; $display("FAIL wrap_out: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", if_valid, if_pc, if_instr, expRec.pc, expRec.instr);
      end
      expPc += 32'd4;
    end
    total++; if (imemBus.imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_zero: got %h want 00000000", imemBus.imem_addr); end
  endtask

  task automatic test_misalign;
`ifdef FETCH_MISALIGN_TRAP_EN
    redirect = 1'b1; next_pc = 32'h102; imemBus.imem_ack = 1'b1;
    tick();
    redirect = 1'b0; #1;
    total++;
    if ({misalign_trap, if_valid, imemBus.imem_req} !== 3'b100) begin
      bad++; $display("FAIL trap_pulse: got trap=%b v=%b req=%b want trap=1 v=0 req=0", misalign_trap, if_valid, imemBus.imem_req);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({misalign_trap, if_valid, imemBus.imem_req} !== 3'b000) begin
        bad++; $display("FAIL trap_hold: got trap=%b v=%b req=%b want trap=0 v=0 req=0", misalign_trap, if_valid, imemBus.imem_req);
      end
    end
`else
    fetchRec_t expRec;
    redirect = 1'b1; next_pc = 32'h102; imemBus.imem_ack = 1'b1;
    tick();
    redirect = 1'b0; #1;
    total++;
    if ({if_valid, imemBus.imem_req, imemBus.imem_addr} !== {1'b0, 1'b1, 32'h100}) begin
      bad++; $display("FAIL misalign_addr: got v=%b req=%b addr=%h want v=0 req=1 addr=00000100", if_valid, imemBus.imem_req, imemBus.imem_addr);
    end
    sb.push_back('{pc: 32'h100, instr: memWord(32'h100)});
    tick();
    total++;
    expRec = sb.pop_front();
    if ({if_valid, if_pc, if_instr} !== {1'b1, expRec.pc, expRec.instr}) begin
      bad++; $display("FAIL misalign_out: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", if_valid, if_pc, if_instr, expRec.pc, expRec.instr);
    end
`endif
  endtask

  task automatic test_reset_midreq;
    fetchRec_t expRec;
    rst = 1'b1; #1;
    tick();
    rst = 1'b0; imemBus.imem_ack = 1'b0; redirect = 1'b0;
    tick(); tick();
    redirect = 1'b1; next_pc = 32'h40;
    tick();
    redirect = 1'b0; #1;
    total++; if ({imemBus.imem_req, imemBus.imem_addr} !== {1'b1, 32'h40}) begin bad++; $display("FAIL midreq_pending: got req=%b addr=%h want req=1 addr=00000040", imemBus.imem_req, imemBus.imem_addr); end
    rst = 1'b1; imemBus.imem_ack = 1'b1; #1;
    total++; if (imemBus.imem_req !== 1'b0) begin bad++; $display("FAIL midreq_rst_req: got %b want 0", imemBus.imem_req); end
    tick();
    total++;
    if ({if_valid, if_pc, imemBus.imem_addr} !== {1'b0, 32'h0, 32'h0}) begin
      bad++; $display("FAIL midreq_after_rst: got v=%b pc=%h addr=%h want v=0 pc=00000000 addr=00000000", if_valid, if_pc, imemBus.imem_addr);
    end
    rst = 1'b0;
    tick();
    total++;
    if ({imemBus.imem_req, imemBus.imem_addr} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL midreq_first: got req=%b addr=%h want req=1 addr=00000000", imemBus.imem_req, imemBus.imem_addr);
    end
    sb.push_back('{pc: 32'h0, instr: memWord(32'h0)});
    tick();
    total++;
    expRec = sb.pop_front();
    if ({if_valid, if_pc, if_instr} !== {1'b1, expRec.pc, expRec.instr}) begin
      bad++; $display("FAIL midreq_out: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", if_valid, if_pc, if_instr, expRec.pc, expRec.instr);
    end
  endtask

  initial begin
    imemBus.imem_ack = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_ack_delay();
    test_wrap();
    test_misalign();
    test_reset_midreq();
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d entries want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
